// File: rtl/lsu.sv
// rtl/lsu.sv - load/store stage: registers EXU results, runs RAM accesses, hands results to WBU
//
// Purpose:
//   Accepts one instruction from EXU (e2l valid/ready), issues a word-wide RAM
//   request for loads/stores, extends load data, and presents the result to the
//   WBU (l2w valid/ready). Non-memory instructions pass through in one cycle.
//
// Ports:
//   i_sys_clk, i_sys_rst       clock, asynchronous active-high reset
//   i_e2l_* / o_lsu_ready      EXU -> LSU instruction handshake and fields
//   o_ram_req_* / i_ram_req_ready   RAM request channel (word address, lane mask/data)
//   i_ram_rsp_* / o_ram_rsp_ready   RAM read response channel
//   o_lsu_* / i_l2w_ready      LSU -> WBU result handshake and fields

`ifndef REG_WR_SRC_X
`define REG_WR_SRC_X   3'd0
`endif
`ifndef REG_WR_SRC_ALU
`define REG_WR_SRC_ALU 3'd1
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 3'd2
`endif
`ifndef RAM_BYT_X
`define RAM_BYT_X      3'd0
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S    3'd1
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U    3'd2
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S    3'd3
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U    3'd4
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S    3'd5
`endif

module lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARGS_WIDTH  = 3,
  parameter int GPRS_WIDTH  = 5,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,

  input  logic                  i_e2l_valid,
  output logic                  o_lsu_ready,
  input  logic [ADDR_WIDTH-1:0] i_e2l_pc,
  input  logic                  i_e2l_ctr_reg_wr_en,
  input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_reg_wr_src,
  input  logic [GPRS_WIDTH-1:0] i_e2l_gpr_rd_id,
  input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_ram_byt,
  input  logic                  i_e2l_ctr_ram_wr_en,
  input  logic [DATA_WIDTH-1:0] i_e2l_res,
  input  logic [DATA_WIDTH-1:0] i_e2l_rs2_data,

  output logic                  o_ram_req_valid,
  input  logic                  i_ram_req_ready,
  output logic [ADDR_WIDTH-1:0] o_ram_req_addr,
  output logic                  o_ram_req_wr_en,
  output logic [3:0]            o_ram_req_wr_mask,
  output logic [DATA_WIDTH-1:0] o_ram_req_wr_data,
  input  logic                  i_ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_ram_rsp_data,
  output logic                  o_ram_rsp_ready,

  output logic                  o_lsu_valid,
  input  logic                  i_l2w_ready,
  output logic [ADDR_WIDTH-1:0] o_lsu_pc,
  output logic                  o_lsu_ctr_reg_wr_en,
  output logic [ARGS_WIDTH-1:0] o_lsu_ctr_reg_wr_src,
  output logic [GPRS_WIDTH-1:0] o_lsu_gpr_rd_id,
  output logic [DATA_WIDTH-1:0] o_lsu_res,
  output logic [DATA_WIDTH-1:0] o_lsu_ram_rd_data,
  output logic                  o_lsu_misalign,
  output logic                  o_lsu_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_OUT} state_t;

  localparam logic [7:0] L_CNT_LAST = 8'(RSP_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  state_t                w_accept_state;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_reg_wr_en;
  logic [ARGS_WIDTH-1:0] r_reg_wr_src;
  logic [GPRS_WIDTH-1:0] r_rd_id;
  logic [ARGS_WIDTH-1:0] r_ram_byt;
  logic                  r_store;
  logic                  r_load;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_rs2;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_misalign;
  logic                  r_bus_err;
  logic [7:0]            r_cnt;

  logic                  w_accept;
  logic                  w_load_in;
  logic                  w_store_in;
  logic                  w_mem_in;
  logic                  w_mis_in;
  logic                  w_timeout;
  logic [4:0]            w_off_bits;
  logic [DATA_WIDTH-1:0] w_rsp_shift;
  logic [DATA_WIDTH-1:0] w_load_ext;

  // ---------------------------------------------------------------------------
  // Accept-side decode
  // ---------------------------------------------------------------------------
  assign w_accept   = i_e2l_valid && o_lsu_ready;
  assign w_store_in = i_e2l_ctr_ram_wr_en;
  assign w_load_in  = (i_e2l_ctr_reg_wr_src == `REG_WR_SRC_MEM) && !i_e2l_ctr_ram_wr_en;
  assign w_mem_in   = w_load_in || w_store_in;

  // Alignment only matters for instructions that actually touch memory.
  always_comb begin
    w_mis_in = 1'b0;
    case (i_e2l_ctr_ram_byt)
      `RAM_BYT_2_S, `RAM_BYT_2_U: w_mis_in = i_e2l_res[0];
      `RAM_BYT_4_S:               w_mis_in = (i_e2l_res[1:0] != 2'b00);
      default:                    w_mis_in = 1'b0;
    endcase
    w_mis_in = w_mis_in && w_mem_in;
  end

  always_comb begin
    w_accept_state = S_OUT;
    if (!w_mis_in && w_mem_in) w_accept_state = S_REQ;
  end

  assign w_timeout = (r_state == S_RSP) && !i_ram_rsp_valid && (r_cnt == L_CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_accept_state;
      S_REQ:  if (i_ram_req_ready) w_next = r_store ? S_OUT : S_RSP;
      S_RSP:  if (i_ram_rsp_valid || w_timeout) w_next = S_OUT;
      S_OUT:  if (i_l2w_ready) w_next = w_accept ? w_accept_state : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Ready in OUT follows the WBU so a new instruction can enter
  // on the same edge the current result leaves.
  always_comb begin
    o_lsu_ready     = (r_state == S_IDLE) || ((r_state == S_OUT) && i_l2w_ready);
    o_lsu_valid     = (r_state == S_OUT);
    o_ram_req_valid = (r_state == S_REQ);
    o_ram_rsp_ready = (r_state == S_RSP);
  end

  // ---------------------------------------------------------------------------
  // Response timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_REQ) && i_ram_req_ready) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_RSP) && !i_ram_rsp_valid) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  assign w_off_bits  = {r_res[1:0], 3'b000};
  assign w_rsp_shift = i_ram_rsp_data >> w_off_bits;

  always_comb begin
    w_load_ext = w_rsp_shift;
    case (r_ram_byt)
      `RAM_BYT_1_S: w_load_ext = {{(DATA_WIDTH-8){w_rsp_shift[7]}}, w_rsp_shift[7:0]};
      `RAM_BYT_1_U: w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_rsp_shift[7:0]};
      `RAM_BYT_2_S: w_load_ext = {{(DATA_WIDTH-16){w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      `RAM_BYT_2_U: w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_rsp_shift[15:0]};
      default:      w_load_ext = w_rsp_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured instruction and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_pc         <= '0;
      r_reg_wr_en  <= 1'b0;
      r_reg_wr_src <= `REG_WR_SRC_X;
      r_rd_id      <= '0;
      r_ram_byt    <= '0;
      r_store      <= 1'b0;
      r_load       <= 1'b0;
      r_res        <= '0;
      r_rs2        <= '0;
      r_rd_data    <= '0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else if (w_accept) begin
      r_pc         <= i_e2l_pc;
      r_reg_wr_en  <= i_e2l_ctr_reg_wr_en && !w_mis_in;
      r_reg_wr_src <= i_e2l_ctr_reg_wr_src;
      r_rd_id      <= i_e2l_gpr_rd_id;
      r_ram_byt    <= i_e2l_ctr_ram_byt;
      r_store      <= w_store_in;
      r_load       <= w_load_in;
      r_res        <= i_e2l_res;
      r_rs2        <= i_e2l_rs2_data;
      r_rd_data    <= '0;
      r_misalign   <= w_mis_in;
      r_bus_err    <= 1'b0;
    end else if (r_state == S_RSP) begin
      if (i_ram_rsp_valid) begin
        r_rd_data <= w_load_ext;
      end else if (w_timeout) begin
        r_bus_err   <= 1'b1;
        r_reg_wr_en <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM request fields, derived from captured registers so they stay stable
  // for the whole REQ wait.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ram_req_addr = r_res[ADDR_WIDTH-1:0];
    o_ram_req_addr[1:0] = 2'b00;
  end

  assign o_ram_req_wr_en   = r_store;
  assign o_ram_req_wr_data = r_rs2 << w_off_bits;

  always_comb begin
    o_ram_req_wr_mask = 4'b0000;
    case (r_ram_byt)
      `RAM_BYT_1_S, `RAM_BYT_1_U: o_ram_req_wr_mask = 4'b0001 << r_res[1:0];
      `RAM_BYT_2_S, `RAM_BYT_2_U: o_ram_req_wr_mask = 4'b0011 << r_res[1:0];
      `RAM_BYT_4_S:               o_ram_req_wr_mask = 4'b1111;
      default:                    o_ram_req_wr_mask = 4'b0000;
    endcase
  end

  // Unused in the datapath beyond this point, kept for completeness of capture.
  logic w_unused;
  assign w_unused = r_load;

  assign o_lsu_pc             = r_pc;
  assign o_lsu_ctr_reg_wr_en  = r_reg_wr_en;
  assign o_lsu_ctr_reg_wr_src = r_reg_wr_src;
  assign o_lsu_gpr_rd_id      = r_rd_id;
  assign o_lsu_res            = r_res;
  assign o_lsu_ram_rd_data    = r_rd_data;
  assign o_lsu_misalign       = r_misalign;
  assign o_lsu_bus_err        = r_bus_err;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a behavioural RAM/result model

`ifndef REG_WR_SRC_X
`define REG_WR_SRC_X   3'd0
`endif
`ifndef REG_WR_SRC_ALU
`define REG_WR_SRC_ALU 3'd1
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 3'd2
`endif
`ifndef RAM_BYT_X
`define RAM_BYT_X      3'd0
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S    3'd1
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U    3'd2
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S    3'd3
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U    3'd4
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S    3'd5
`endif

module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        e2l_valid, lsu_ready;
  logic [31:0] e2l_pc, e2l_res, e2l_rs2;
  logic        e2l_wr_en, e2l_ram_wr_en;
  logic [2:0]  e2l_src, e2l_byt;
  logic [4:0]  e2l_rd;
  logic        req_valid, req_ready, req_wr_en;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_mask;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        lsu_valid, l2w_ready;
  logic [31:0] o_pc, o_res, o_rd_data;
  logic        o_wr_en, o_mis, o_err;
  logic [2:0]  o_src;
  logic [4:0]  o_rd;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  lsu #(.RSP_TIMEOUT(TO)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_e2l_valid(e2l_valid), .o_lsu_ready(lsu_ready), .i_e2l_pc(e2l_pc),
    .i_e2l_ctr_reg_wr_en(e2l_wr_en), .i_e2l_ctr_reg_wr_src(e2l_src),
    .i_e2l_gpr_rd_id(e2l_rd), .i_e2l_ctr_ram_byt(e2l_byt),
    .i_e2l_ctr_ram_wr_en(e2l_ram_wr_en), .i_e2l_res(e2l_res), .i_e2l_rs2_data(e2l_rs2),
    .o_ram_req_valid(req_valid), .i_ram_req_ready(req_ready), .o_ram_req_addr(req_addr),
    .o_ram_req_wr_en(req_wr_en), .o_ram_req_wr_mask(req_mask), .o_ram_req_wr_data(req_data),
    .i_ram_rsp_valid(rsp_valid), .i_ram_rsp_data(rsp_data), .o_ram_rsp_ready(rsp_ready),
    .o_lsu_valid(lsu_valid), .i_l2w_ready(l2w_ready), .o_lsu_pc(o_pc),
    .o_lsu_ctr_reg_wr_en(o_wr_en), .o_lsu_ctr_reg_wr_src(o_src), .o_lsu_gpr_rd_id(o_rd),
    .o_lsu_res(o_res), .o_lsu_ram_rd_data(o_rd_data), .o_lsu_misalign(o_mis),
    .o_lsu_bus_err(o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_e2l(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rs2,
                           input logic [2:0] src, input logic [2:0] byt, input logic wr_en,
                           input logic st, input logic [4:0] rd);
    e2l_valid = 1'b1; e2l_pc = pc; e2l_res = res; e2l_rs2 = rs2; e2l_src = src;
    e2l_byt = byt; e2l_wr_en = wr_en; e2l_ram_wr_en = st; e2l_rd = rd;
  endtask

  task automatic scramble_e2l();
    e2l_valid = 1'b0; e2l_pc = $urandom; e2l_res = $urandom; e2l_rs2 = $urandom;
    e2l_src = 3'($urandom); e2l_byt = 3'($urandom); e2l_wr_en = 1'($urandom);
    e2l_ram_wr_en = 1'($urandom); e2l_rd = 5'($urandom);
  endtask

  // One complete instruction from accept to WBU handshake, with the model
  // deciding what each channel must show.
  task automatic txn(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rs2,
                     input logic [2:0] src, input logic [2:0] byt, input logic wr_en,
                     input logic st, input logic [4:0] rd,
                     input int req_w, input int rsp_w, input int out_w, input bit no_rsp);
    int          size, off;
    bit          ld, mem_op, mis, err, sgn;
    logic [31:0] addr, exp_data, word, exp_rd;
    logic [3:0]  exp_mask;
    longint      v;

    ld     = (src == `REG_WR_SRC_MEM) && !st;
    mem_op = ld || st;
    size   = (byt == `RAM_BYT_1_S || byt == `RAM_BYT_1_U) ? 1 :
             (byt == `RAM_BYT_2_S || byt == `RAM_BYT_2_U) ? 2 : 4;
    sgn    = (byt == `RAM_BYT_1_S || byt == `RAM_BYT_2_S || byt == `RAM_BYT_4_S);
    off    = int'(res % 4);
    mis    = mem_op && ((res % size) != 0);
    addr   = res - 32'(off);
    exp_mask = 4'(((1 << size) - 1) << off);
    exp_data = 32'(64'(rs2) << (8 * off));
    if (!mem.exists(addr)) mem[addr] = $urandom;
    word   = mem[addr];
    v      = longint'((64'(word) >> (8 * off)) % (64'd1 << (8 * size)));
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    exp_rd = 32'(v);
    err    = 1'b0;

    @(negedge clk);
    drive_e2l(pc, res, rs2, src, byt, wr_en, st, rd);
    #1 chk("ready_idle", 32'(lsu_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    scramble_e2l();

    if (mem_op && !mis) begin
      for (int i = 0; i <= req_w; i++) begin
        req_ready = (i == req_w);
        #1;
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr",  req_addr, addr);
        chk("req_wr_en", 32'(req_wr_en), 32'(st));
        if (st) begin
          chk("req_mask", 32'(req_mask), 32'(exp_mask));
          chk("req_data", req_data, exp_data);
        end
        @(posedge clk);
        @(negedge clk);
      end
      req_ready = 1'b0;
      if (st) begin
        for (int b = 0; b < 4; b++)
          if (exp_mask[b]) mem[addr][8*b +: 8] = exp_data[8*b +: 8];
      end else if (no_rsp) begin
        for (int i = 0; i < TO; i++) begin
          #1 chk("rsp_ready_to", 32'(rsp_ready), 32'd1);
          @(posedge clk);
          @(negedge clk);
        end
        err = 1'b1;
      end else begin
        for (int i = 0; i <= rsp_w; i++) begin
          rsp_valid = (i == rsp_w);
          rsp_data  = (i == rsp_w) ? word : $urandom;
          #1 chk("rsp_ready", 32'(rsp_ready), 32'd1);
          @(posedge clk);
          @(negedge clk);
        end
        rsp_valid = 1'b0;
      end
    end

    // In OUT; stray responses are offered and must be refused.
    for (int i = 0; i <= out_w; i++) begin
      l2w_ready = (i == out_w);
      rsp_valid = 1'($urandom);
      rsp_data  = $urandom;
      #1;
      chk("lsu_valid",  32'(lsu_valid), 32'd1);
      chk("out_ready",  32'(lsu_ready), 32'(l2w_ready));
      chk("out_rspr",   32'(rsp_ready), 32'd0);
      chk("out_reqv",   32'(req_valid), 32'd0);
      chk("out_pc",     o_pc, pc);
      chk("out_src",    32'(o_src), 32'(src));
      chk("out_rd",     32'(o_rd), 32'(rd));
      chk("out_res",    o_res, res);
      chk("out_wr_en",  32'(o_wr_en), 32'(wr_en && !mis && !err));
      chk("out_rddata", o_rd_data, (ld && !mis && !err) ? exp_rd : 32'd0);
      chk("out_mis",    32'(o_mis), 32'(mis));
      chk("out_err",    32'(o_err), 32'(err));
      @(posedge clk);
      @(negedge clk);
    end
    l2w_ready = 1'b0;
    rsp_valid = 1'b0;
    #1 chk("back_idle", 32'(lsu_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    scramble_e2l();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; l2w_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid",  32'(lsu_valid), 32'd0);
    chk("rst_reqv",   32'(req_valid), 32'd0);
    chk("rst_rspr",   32'(rsp_ready), 32'd0);
    chk("rst_src",    32'(o_src), 32'(`REG_WR_SRC_X));
    chk("rst_pc",     o_pc, 32'd0);
    chk("rst_rddata", o_rd_data, 32'd0);
    chk("rst_flags",  32'({o_mis, o_err, o_wr_en}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back ALU ops with no bubble
    @(negedge clk);
    drive_e2l(32'h100, 32'h1234, 32'h0, `REG_WR_SRC_ALU, `RAM_BYT_X, 1'b1, 1'b0, 5'd5);
    l2w_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_e2l(32'h104, 32'h5678, 32'h0, `REG_WR_SRC_ALU, `RAM_BYT_X, 1'b1, 1'b0, 5'd6);
    #1;
    chk("b2b_valid1", 32'(lsu_valid), 32'd1);
    chk("b2b_res1",   o_res, 32'h1234);
    chk("b2b_rd1",    32'(o_rd), 32'd5);
    chk("b2b_rdy",    32'(lsu_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    scramble_e2l();
    #1;
    chk("b2b_valid2", 32'(lsu_valid), 32'd1);
    chk("b2b_res2",   o_res, 32'h5678);
    chk("b2b_rd2",    32'(o_rd), 32'd6);
    @(posedge clk);
    @(negedge clk);
    l2w_ready = 1'b0;
    #1 chk("b2b_idle", 32'(lsu_valid), 32'd0);

    // Directed memory cases
    txn(32'h200, 32'h1003, 32'hAABBCCDD, `REG_WR_SRC_X, `RAM_BYT_1_S, 1'b0, 1'b1, 5'd0, 3, 0, 0, 0);
    chk("sb_mem", mem[32'h1000] & 32'hFF000000, 32'hDD000000);
    mem[32'h2000] = 32'h000080FF;
    txn(32'h204, 32'h2001, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_1_S, 1'b1, 1'b0, 5'd7, 0, 2, 0, 0);
    txn(32'h208, 32'h2001, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_1_U, 1'b1, 1'b0, 5'd8, 1, 2, 0, 0);
    mem[32'h2000] = 32'h80010000;
    txn(32'h20C, 32'h2002, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_2_S, 1'b1, 1'b0, 5'd9, 0, 1, 0, 0);
    txn(32'h210, 32'h3002, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_4_S, 1'b1, 1'b0, 5'd10, 0, 0, 0, 0);
    txn(32'h214, 32'h2010, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_4_S, 1'b1, 1'b0, 5'd11, 0, 0, 2, 1);
    txn(32'h218, 32'h4321, 32'h0, `REG_WR_SRC_ALU, `RAM_BYT_X, 1'b1, 1'b0, 5'd12, 0, 0, 5, 0);

    // Reset in the middle of RSP
    @(negedge clk);
    drive_e2l(32'h300, 32'h2004, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_4_S, 1'b1, 1'b0, 5'd3);
    @(posedge clk);
    @(negedge clk);
    scramble_e2l();
    req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_ready = 1'b0;
    #1 chk("rsp_before_rst", 32'(rsp_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm_rspr",  32'(rsp_ready), 32'd0);
    chk("rstm_valid", 32'(lsu_valid), 32'd0);
    chk("rstm_pc",    o_pc, 32'd0);
    chk("rstm_res",   o_res, 32'd0);
    chk("rstm_rdy",   32'(lsu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'hDEADBEEF;
    #1 chk("rstm_ignore", 32'(rsp_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1 chk("rstm_idle", 32'(lsu_valid), 32'd0);
    txn(32'h304, 32'h2004, 32'h0, `REG_WR_SRC_MEM, `RAM_BYT_4_S, 1'b1, 1'b0, 5'd3, 1, 1, 0, 0);

    // Randomized instruction mix against the model
    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [31:0] res;
      logic [2:0]  byt;
      kind = int'($urandom_range(0, 2));
      res  = 32'h2000 + 32'($urandom_range(0, 63));
      case (kind)
        0: txn($urandom, $urandom, $urandom, `REG_WR_SRC_ALU, 3'($urandom), 1'($urandom), 1'b0,
               5'($urandom), 0, 0, int'($urandom_range(0, 2)), 0);
        1: begin
          byt = 3'($urandom_range(1, 5));
          txn($urandom, res, 32'h0, `REG_WR_SRC_MEM, byt, 1'b1, 1'b0, 5'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
              int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
        end
        default: begin
          byt = ($urandom_range(0, 2) == 0) ? `RAM_BYT_1_S :
                ($urandom_range(0, 1) == 0) ? `RAM_BYT_2_S : `RAM_BYT_4_S;
          txn($urandom, res, $urandom, `REG_WR_SRC_X, byt, 1'b0, 1'b1, 5'($urandom),
              int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 2)), 0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage of the l2 core pipeline; the receiving end of the EXU→LSU (e2l) valid/ready handshake.
- Registers EXU results. Loads and stores are issued to a word-wide data RAM through a request/response handshake.
- Forwards the result (ALU value or load data) to the WBU through the l2w valid/ready handshake.
- Non-memory instructions pass through in one cycle.

Parameters:
- RSP_TIMEOUT, 255, maximum cycles spent in RSP before the access is abandoned as a bus error (1..255).

Ports:
- i_sys_clk  in  1  core clock
- i_sys_rst  in  1  asynchronous active-high reset
- i_e2l_valid  in  1  EXU output valid
- o_lsu_ready  out  1  LSU can accept from EXU
- i_e2l_pc  in  ADDR_WIDTH  instruction pc
- i_e2l_ctr_reg_wr_en  in  1  GPR write enable
- i_e2l_ctr_reg_wr_src  in  ARGS_WIDTH  writeback source; `REG_WR_SRC_MEM marks a load
- i_e2l_gpr_rd_id  in  GPRS_WIDTH  destination register
- i_e2l_ctr_ram_byt  in  ARGS_WIDTH  access size/sign: `RAM_BYT_1_S, `RAM_BYT_1_U, `RAM_BYT_2_S, `RAM_BYT_2_U, `RAM_BYT_4_S
- i_e2l_ctr_ram_wr_en  in  1  store
- i_e2l_res  in  DATA_WIDTH  ALU result / effective address
- i_e2l_rs2_data  in  DATA_WIDTH  store data
- o_ram_req_valid  out  1  RAM request valid
- i_ram_req_ready  in  1  RAM accepts request
- o_ram_req_addr  out  ADDR_WIDTH  word address, equal to res with bits [1:0] cleared
- o_ram_req_wr_en  out  1  request is a write
- o_ram_req_wr_mask  out  4  byte-lane enables
- o_ram_req_wr_data  out  DATA_WIDTH  lane-aligned write data
- i_ram_rsp_valid  in  1  read data valid
- i_ram_rsp_data  in  DATA_WIDTH  read word
- o_ram_rsp_ready  out  1  LSU accepts response
- o_lsu_valid  out  1  result valid to WBU
- i_l2w_ready  in  1  WBU accepts
- o_lsu_pc  out  ADDR_WIDTH  captured pc
- o_lsu_ctr_reg_wr_en  out  1  GPR write enable; forced 0 on error
- o_lsu_ctr_reg_wr_src  out  ARGS_WIDTH  captured writeback source
- o_lsu_gpr_rd_id  out  GPRS_WIDTH  captured destination register
- o_lsu_res  out  DATA_WIDTH  captured ALU result
- o_lsu_ram_rd_data  out  DATA_WIDTH  extended load data; 0 for non-loads
- o_lsu_misalign  out  1  access was misaligned
- o_lsu_bus_err  out  1  response timed out

Behaviour:
Reset (async, i_sys_rst=1):
- State = IDLE. All registered outputs are 0; o_lsu_ctr_reg_wr_src = `REG_WR_SRC_X.
- o_lsu_valid, o_ram_req_valid and o_ram_rsp_ready are 0.
- Timeout counter is cleared.
- Reset mid-access drops the access silently; no RAM response is consumed afterwards.

FSM states: IDLE, REQ, RSP, OUT.
- o_lsu_ready = (state==IDLE) || (state==OUT && i_l2w_ready). This is combinational and permits back-to-back acceptance.
- Accept when i_e2l_valid && o_lsu_ready. All i_e2l_* fields are captured and misalignment is computed:
  - 2-byte access with res[0]=1 is misaligned.
  - 4-byte access with res[1:0]!=0 is misaligned.
- From accept:
  - Misaligned → OUT, with o_lsu_misalign=1 and o_lsu_ctr_reg_wr_en=0. No RAM request is issued.
  - Load or store → REQ.
  - Anything else → OUT, with o_lsu_ram_rd_data=0.
- REQ:
  - o_ram_req_valid=1; addr, wr_en, mask and data are held stable until i_ram_req_ready.
  - Store mask: 1B = 4'b0001<<off; 2B = 4'b0011<<off; 4B = 4'b1111.
  - Store data: rs2 << (8*off), where off = res[1:0].
  - On handshake: a store goes to OUT; a load goes to RSP and clears the counter.
- RSP:
  - o_ram_rsp_ready=1.
  - On i_ram_rsp_valid, the word is captured as w = i_ram_rsp_data >> (8*off), then extended: 1_S sign-extends w[7:0]; 1_U zero-extends w[7:0]; 2_S/2_U do the same on w[15:0]; 4_S passes w through. State → OUT.
  - Otherwise the counter increments. When the counter reaches RSP_TIMEOUT → OUT with o_lsu_bus_err=1 and o_lsu_ctr_reg_wr_en=0.
- OUT:
  - o_lsu_valid=1; outputs are held until i_l2w_ready.
  - Handshake without a simultaneous accept → IDLE.
  - Handshake with a simultaneous accept → the same transitions as from IDLE.
  - Flags clear on each new accept.
- A response that arrives while not in RSP is ignored, since o_ram_rsp_ready=0.

Latency (i_l2w_ready held 1):
- Non-memory instruction: valid on the cycle after accept; throughput 1/cycle.
- Store: 1 + request-wait cycles.
- Load: request-wait + response-wait + 1.

Test Plan:
- ALU op, res=0x1234, rd=5, reg_wr_en=1, i_l2w_ready=1 → o_lsu_valid the next cycle with o_lsu_res=0x1234 and rd=5. A second op on the following cycle is accepted with no bubble.
- Store sb, res=0x1003, rs2=0xAABBCCDD → req addr=0x1000, mask=4'b1000, wr_data=0xDD000000, wr_en=1. Holding req_ready=0 for 3 cycles keeps the request stable.
- Load lb_s, res=0x2001, rsp data=0x0000_80FF after 2 cycles → o_lsu_ram_rd_data=0xFFFFFF80. lbu on the same data → 0x00000080. lh_s at res=0x2002 with data=0x8001_0000 → 0xFFFF8001.
- lw at res=0x3002 → no RAM request; o_lsu_misalign=1 and reg_wr_en=0 in OUT.
- Load with RSP_TIMEOUT=4 and no rsp_valid → o_lsu_bus_err=1 after 4 RSP cycles; a late rsp_valid is ignored.
- i_l2w_ready=0 for 5 cycles in OUT → o_lsu_ready=0 and outputs stable. Asserting i_sys_rst during RSP → state returns to IDLE, outputs are 0 immediately, and the next accept behaves normally.
